// File: rtl/idma_desc64_reg_frontend_pkg.sv
// Register map, STATUS layout and register-bus payload types for the desc64 frontend.
package idma_desc64_reg_frontend_pkg;

  localparam int unsigned REG_DESC_ADDR = 32'h00;
  localparam int unsigned REG_STATUS    = 32'h08;
  localparam int unsigned REG_MAP_SIZE  = 32'h10;

  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_EMPTY_BIT = 2;
  localparam int unsigned STATUS_IRQ_BIT   = 3;
  localparam int unsigned STATUS_FILL_LSB  = 8;
  localparam int unsigned STATUS_FILL_W    = 8;
  localparam int unsigned STATUS_DONE_LSB  = 32;
  localparam int unsigned STATUS_DONE_W    = 32;

  typedef struct packed {
    logic [STATUS_DONE_W-1:0] done_cnt;
    logic [15:0]              rsvd_hi;
    logic [STATUS_FILL_W-1:0] fill;
    logic [3:0]               rsvd_lo;
    logic                     irq_pending;
    logic                     empty;
    logic                     full;
    logic                     busy;
  } status_t;

  typedef struct packed {
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/idma_desc64_addr_fifo.sv
// Synchronous descriptor-pointer FIFO; extra pointer bit separates full from empty.
module idma_desc64_addr_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(Depth):0]   fill_c
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q;
  logic [PtrW:0]    rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign fill_c  = wr_ptr_q - rd_ptr_q;
  // Head is forced to zero when empty so the downstream pointer is clean after reset.
  assign head_c  = empty_c ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/idma_desc64_reg_frontend.sv
// Register-bus slave exposing DESC_ADDR (pointer queue) and STATUS to the desc64 fetcher.
// Optional irq_o and STATUS.irq_pending under `IDMA_DESC64_REG_FRONTEND_IRQ_EN.
module idma_desc64_reg_frontend
  import idma_desc64_reg_frontend_pkg::*;
#(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_req_valid_i,
  output logic                 reg_req_ready_o,
  input  logic                 reg_req_write_i,
  input  logic [AddrWidth-1:0] reg_req_addr_i,
  input  logic [63:0]          reg_req_wdata_i,
  input  logic [7:0]           reg_req_wstrb_i,
  output logic                 reg_rsp_valid_o,
  input  logic                 reg_rsp_ready_i,
  output logic [63:0]          reg_rsp_rdata_o,
  output logic                 reg_rsp_error_o,
  output logic [63:0]          desc_addr_o,
  output logic                 desc_addr_valid_o,
  input  logic                 desc_addr_ready_i,
  input  logic                 fetch_busy_i,
`ifdef IDMA_DESC64_REG_FRONTEND_IRQ_EN
  output logic                 irq_o,
`endif
  input  logic                 desc_done_i
);

  localparam int unsigned FillW = $clog2(FifoDepth) + 1;

  reg_req_t            req_c;
  reg_rsp_t            rsp_c;
  reg_rsp_t            rsp_q;
  status_t             status_c;
  logic                rsp_valid_q;
  logic [63:0]         last_addr_q;
  logic [CntWidth-1:0] done_cnt_q;
  logic                irq_pending_q;
  logic                accept;
  logic                hit_desc;
  logic                hit_status;
  logic                push;
  logic                status_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FillW-1:0]    fifo_fill;

  assign req_c = '{write: reg_req_write_i, wdata: reg_req_wdata_i, wstrb: reg_req_wstrb_i};

  assign reg_req_ready_o = !rst_i && (!rsp_valid_q || reg_rsp_ready_i);
  assign accept          = reg_req_valid_i && reg_req_ready_o;
  assign hit_desc        = (reg_req_addr_i == AddrWidth'(REG_DESC_ADDR));
  assign hit_status      = (reg_req_addr_i == AddrWidth'(REG_STATUS));
  // Fullness is the registered state, so a same-cycle pop never admits a write to a full queue.
  assign push            = accept && req_c.write && hit_desc && (req_c.wstrb == 8'hFF) && !fifo_full;
  assign status_rd       = accept && !req_c.write && hit_status;

  idma_desc64_addr_fifo #(
    .Depth (FifoDepth),
    .Width (64)
  ) i_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push),
    .pop     (desc_addr_ready_i),
    .wdata   (req_c.wdata),
    .head_c  (desc_addr_o),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .fill_c  (fifo_fill)
  );

  assign desc_addr_valid_o = !fifo_empty;

  always_comb begin
    status_c             = '0;
    status_c.busy        = !fifo_empty || fetch_busy_i;
    status_c.full        = fifo_full;
    status_c.empty       = fifo_empty;
    status_c.fill        = STATUS_FILL_W'(fifo_fill);
    status_c.done_cnt    = STATUS_DONE_W'(done_cnt_q);
    status_c.irq_pending = irq_pending_q;
  end

  // Response decode; rdata stays zero for writes and for any error.
  always_comb begin
    rsp_c = '0;
    if (hit_desc) begin
      if (req_c.write) rsp_c.error = !((req_c.wstrb == 8'hFF) && !fifo_full);
      else             rsp_c.rdata = last_addr_q;
    end else if (hit_status) begin
      if (req_c.write) rsp_c.error = 1'b1;
      else             rsp_c.rdata = status_c;
    end else begin
      rsp_c.error = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      last_addr_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_q       <= rsp_c;
      end else if (reg_rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
        rsp_q       <= '0;
      end
      if (push)        last_addr_q <= req_c.wdata;
      if (desc_done_i) done_cnt_q  <= done_cnt_q + CntWidth'(1);
    end
  end

  assign reg_rsp_valid_o = rsp_valid_q;
  assign reg_rsp_rdata_o = rsp_q.rdata;
  assign reg_rsp_error_o = rsp_q.error;

`ifdef IDMA_DESC64_REG_FRONTEND_IRQ_EN
  logic irq_q;

  // A completion in the same cycle as a STATUS read keeps the pending flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q         <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_q <= desc_done_i;
      if (desc_done_i)    irq_pending_q <= 1'b1;
      else if (status_rd) irq_pending_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_pending_q = 1'b0;
`endif

endmodule

// File: doc/idma_desc64_reg_frontend.md
Name: idma_desc64_reg_frontend

Overview:
- Register-bus slave that implements the 64-bit descriptor frontend map:
  - DESC_ADDR at offset 0x00.
  - STATUS at offset 0x08.
  - Map size 0x10.
- Software writes of DESC_ADDR are queued in a small FIFO and presented downstream as a valid/ready stream of descriptor pointers to the descriptor fetcher.
- STATUS reports queue occupancy, busy state and completed-descriptor count.
- Sits between the host register interconnect and the idma_desc64 fetch/backend path.

Parameters:
- AddrWidth, 4, register-bus address width (byte address within the map).
- FifoDepth, 4, descriptor-pointer queue depth; power of two, at least 2.
- CntWidth, 32, width of the completed-descriptor counter; at most 32.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- reg_req_valid_i  in  1  request valid.
- reg_req_ready_o  out  1  request accepted when valid&ready.
- reg_req_write_i  in  1  1=write, 0=read.
- reg_req_addr_i  in  AddrWidth  byte address.
- reg_req_wdata_i  in  64  write data.
- reg_req_wstrb_i  in  8  byte strobes.
- reg_rsp_valid_o  out  1  response valid.
- reg_rsp_ready_i  in  1  response accepted.
- reg_rsp_rdata_o  out  64  read data (0 for writes and errors).
- reg_rsp_error_o  out  1  access error.
- desc_addr_o  out  64  descriptor pointer to fetcher.
- desc_addr_valid_o  out  1  pointer valid.
- desc_addr_ready_i  in  1  fetcher accepts pointer.
- fetch_busy_i  in  1  fetcher/backend has descriptors in flight.
- desc_done_i  in  1  one-cycle pulse per completed descriptor.

Behaviour:
- Reset:
  - All outputs are 0: reg_req_ready_o=0, rsp_valid=0, rdata=0, error=0, desc_addr_o=0, desc_addr_valid_o=0.
  - FIFO is emptied, done counter=0, last_addr=0, any pending response is discarded.
  - reg_req_ready_o becomes 1 on the first cycle after rst_i deasserts.
- Request/response handshake:
  - One outstanding access at a time.
  - reg_req_ready_o = !rsp_pending | reg_rsp_ready_i.
  - An accepted request produces reg_rsp_valid_o on the next cycle.
  - Response is held stable until reg_rsp_ready_i.
  - Back-to-back accesses run at 1 per cycle while reg_rsp_ready_i=1.
- Decode:
  - addr[2:0] must be 0.
  - addr == 0x00 → DESC_ADDR, addr == 0x08 → STATUS.
  - Any other address → error response; no side effects; rdata=0.
- DESC_ADDR write:
  - Requires wstrb == 8'hFF and FIFO not full, with fullness sampled at the start of the acceptance cycle.
  - On success: push wdata, update last_addr, error=0.
  - Otherwise: error=1 and no push.
  - A pop in the same cycle as the push does not rescue a write to a full FIFO.
- DESC_ADDR read: returns last_addr, which is the last successfully pushed pointer.
- STATUS:
  - Read-only; a write returns error=1 with no effect.
  - Read fields:
    - [0] busy = fifo non-empty | fetch_busy_i.
    - [1] full.
    - [2] empty.
    - [15:8] fill level, zero-extended.
    - [63:32] done count, zero-extended.
- Downstream stream:
  - desc_addr_valid_o = FIFO non-empty.
  - desc_addr_o = FIFO head.
  - Pop on valid&ready.
  - There is no bypass: a push to an empty FIFO becomes visible the next cycle.
  - Pointer order equals write order.
- Fill level:
  - Simultaneous push and pop leaves the fill unchanged.
  - Pointers wrap modulo FifoDepth, with an extra bit for full/empty.
- Done counter:
  - Increments on each desc_done_i.
  - Wraps from all-ones to 0.
  - A read in the same cycle as a pulse returns the pre-increment value.

Optional Feature:
- Macro: IDMA_DESC64_REG_FRONTEND_IRQ_EN.
- When defined:
  - Adds output irq_o (1 bit).
  - irq_o is a registered 1-cycle pulse the cycle after each desc_done_i.
  - Adds STATUS[3] = sticky irq_pending, set on desc_done_i.
  - irq_pending is cleared by a STATUS read; set wins over clear when both happen in the same cycle.
- When undefined: no irq_o port, and STATUS[3] reads 0.

Decomposition:
- Package idma_desc64_reg_frontend_pkg holds:
  - Register offsets (0x00, 0x08) and map size 0x10.
  - STATUS bit-position constants.
  - status_t packed struct.
  - A reg request/response typedef pair.
- One sub-module: idma_desc64_addr_fifo, a synchronous FIFO parameterised by Depth, with push/pop, full/empty and fill outputs.

Test Plan:
- Write DESC_ADDR=64'h0000_0000_8000_1000 with wstrb=FF, desc_addr_ready_i=1 → rsp error=0 next cycle; desc_addr_valid_o=1 with 0x80001000 one cycle later; popped.
- With desc_addr_ready_i=0, 5 writes at FifoDepth=4 → first 4 return error=0; 5th returns error=1; STATUS read = full=1, fill=4, busy=1; release ready → pointers emerge in write order.
- Write DESC_ADDR with wstrb=0F; access 0x04; access 0x10; write STATUS → each returns error=1; fill stays 0; last_addr unchanged.
- Three desc_done_i pulses, then read STATUS → [63:32]=3; preload counter at all-ones and pulse once → wraps to 0.
- Hold reg_rsp_ready_i=0 for 3 cycles after a read → reg_req_ready_o=0 and rsp held stable; assert rst_i mid-queue with 2 entries → next cycle desc_addr_valid_o=0 and rsp_valid=0; STATUS then reads empty=1.
- With IDMA_DESC64_REG_FRONTEND_IRQ_EN: desc_done_i pulse → irq_o=1 for exactly 1 cycle; STATUS[3]=1; after the read STATUS[3]=0.
